// File: rtl/wash_phase_timer.sv
// Wash-cycle sequencer: FILL -> WASH -> SPIN -> DONE with a per-cycle WASH length.
// All outputs are registered; comp_time/comp_time2 pulse on the edge that leaves WASH/FILL.
module wash_phase_timer #(
  parameter int unsigned W         = 8,
  parameter int unsigned FILL_TIME = 5,
  parameter int unsigned SPIN_TIME = 8,
  parameter int unsigned PRESET1   = 10,
  parameter int unsigned PRESET2   = 16,
  parameter int unsigned PRESET3   = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic [1:0]   control_preset,
  input  logic [W-1:0] washing_time,
  output logic [W-1:0] count,
  output logic [2:0]   phase,
  output logic         comp_time,
  output logic         comp_time2,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_WASH = 3'd2,
    S_SPIN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [W-1:0] FILL_L = W'(FILL_TIME);
  localparam logic [W-1:0] SPIN_L = W'(SPIN_TIME);
  localparam logic [W-1:0] P1_L   = W'(PRESET1);
  localparam logic [W-1:0] P2_L   = W'(PRESET2);
  localparam logic [W-1:0] P3_L   = W'(PRESET3);

  state_t       state, state_n;
  logic [W-1:0] count_n;
  logic [W-1:0] target, target_n;
  logic [W-1:0] sel_target;
  logic [W-1:0] lim;
  logic         comp_n, comp2_n, err_n, busy_n, done_n;

  always_comb begin
    sel_target = washing_time;
    case (control_preset)
      2'b01:   sel_target = P1_L;
      2'b10:   sel_target = P2_L;
      2'b11:   sel_target = P3_L;
      default: sel_target = washing_time;
    endcase
  end

  always_comb begin
    lim = FILL_L;
    case (state)
      S_WASH:  lim = target;
      S_SPIN:  lim = SPIN_L;
      default: lim = FILL_L;
    endcase
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    target_n = target;
    comp_n   = 1'b0;
    comp2_n  = 1'b0;
    err_n    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        count_n = '0;
        if (abort) begin
          state_n = S_IDLE;
        end else if (start) begin
          if (control_preset == 2'b00 && washing_time == '0) begin
            err_n = 1'b1;
          end else begin
            target_n = sel_target;
            state_n  = S_FILL;
          end
        end
      end
      S_FILL, S_WASH, S_SPIN: begin
        if (abort) begin
          state_n = S_IDLE;
          count_n = '0;
        end else if (!pause && tick) begin
          if (count == lim - W'(1)) begin
            count_n = '0;
            comp2_n = (state == S_FILL);
            comp_n  = (state == S_WASH);
            case (state)
              S_FILL:  state_n = S_WASH;
              S_WASH:  state_n = S_SPIN;
              default: state_n = S_DONE;
            endcase
          end else begin
            count_n = count + W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        count_n = '0;
      end
    endcase
    busy_n = (state_n == S_FILL) || (state_n == S_WASH) || (state_n == S_SPIN);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      target     <= '0;
      comp_time  <= 1'b0;
      comp_time2 <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      target     <= target_n;
      comp_time  <= comp_n;
      comp_time2 <= comp2_n;
      err        <= err_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with hand-computed expected sequences.
module tb_wash_phase_timer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         tick;
  logic         start;
  logic         pause;
  logic         abort;
  logic [1:0]   control_preset;
  logic [W-1:0] washing_time;
  logic [W-1:0] count;
  logic [2:0]   phase;
  logic         comp_time, comp_time2, busy, done, err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  wash_phase_timer #(
    .W(W), .FILL_TIME(5), .SPIN_TIME(8), .PRESET1(10), .PRESET2(16), .PRESET3(21)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause),
    .abort(abort), .control_preset(control_preset), .washing_time(washing_time),
    .count(count), .phase(phase), .comp_time(comp_time), .comp_time2(comp_time2),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int unsigned ph, input int unsigned cnt,
                            input int unsigned c, input int unsigned c2,
                            input int unsigned b, input int unsigned d);
    check({tag, ".phase"}, phase, ph);
    check({tag, ".count"}, count, cnt);
    check({tag, ".comp_time"}, comp_time, c);
    check({tag, ".comp_time2"}, comp_time2, c2);
    check({tag, ".busy"}, busy, b);
    check({tag, ".done"}, done, d);
  endtask

  task automatic go_idle();
    abort = 1'b1; start = 1'b0; pause = 1'b0;
    step();
    abort = 1'b0;
  endtask

  int unsigned busy_cycles, comp_cyc, done_cyc, fill_cycles, c2_cycles;
  int unsigned exp_ph, exp_cnt;

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    control_preset = 2'b00; washing_time = '0;
    #2;
    expect_all("reset", 0, 0, 0, 0, 0, 0);
    check("reset.err", err, 0);
    #10 rst_n = 1'b1;
    step();
    expect_all("post_reset", 0, 0, 0, 0, 0, 0);

    // Test 1: preset 01, full cycle with tick every clock.
    tick = 1'b1; control_preset = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    busy_cycles = 0;
    for (int unsigned c = 0; c < 23; c++) begin
      exp_ph  = (c < 5) ? 1 : (c < 15) ? 2 : 3;
      exp_cnt = (c < 5) ? c : (c < 15) ? c - 5 : c - 15;
      expect_all($sformatf("t1.c%0d", c), exp_ph, exp_cnt,
                 (c == 15) ? 1 : 0, (c == 5) ? 1 : 0, 1, 0);
      if (busy) busy_cycles++;
      step();
    end
    expect_all("t1.done", 4, 0, 0, 0, 0, 1);
    check("t1.busy_cycles", busy_cycles, 23);
    step();
    expect_all("t1.done_hold", 4, 0, 0, 0, 0, 1);
    go_idle();

    // Test 2: user time 3 latched; later changes ignored.
    control_preset = 2'b00; washing_time = 8'd3; start = 1'b1;
    step();
    start = 1'b0; washing_time = 8'd50;
    for (int unsigned c = 0; c < 9; c++) begin
      exp_ph  = (c < 5) ? 1 : (c < 8) ? 2 : 3;
      exp_cnt = (c < 5) ? c : (c < 8) ? c - 5 : 0;
      expect_all($sformatf("t2.c%0d", c), exp_ph, exp_cnt,
                 (c == 8) ? 1 : 0, (c == 5) ? 1 : 0, 1, 0);
      step();
    end
    go_idle();

    // Test 3: preset 10, pause for 4 cycles at WASH count 7.
    control_preset = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    comp_cyc = 999; done_cyc = 999;
    for (int unsigned c = 0; c < 60 && done_cyc == 999; c++) begin
      if (c == 12) begin
        check("t3.pre_pause_phase", phase, 2);
        check("t3.pre_pause_count", count, 7);
        pause = 1'b1;
      end
      if (c >= 13 && c <= 16) begin
        check($sformatf("t3.hold%0d.count", c), count, 7);
        check($sformatf("t3.hold%0d.phase", c), phase, 2);
      end
      if (c == 16) pause = 1'b0;
      if (c == 17) check("t3.resume_count", count, 8);
      if (comp_time && comp_cyc == 999) comp_cyc = c;
      if (done) done_cyc = c;
      else step();
    end
    check("t3.comp_cycle", comp_cyc, 25);
    check("t3.done_cycle", done_cyc, 33);
    go_idle();

    // Test 4a: abort during SPIN count 3.
    control_preset = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    for (int unsigned c = 0; c < 18; c++) step();
    check("t4a.spin_phase", phase, 3);
    check("t4a.spin_count", count, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_all("t4a.aborted", 0, 0, 0, 0, 0, 0);
    step();
    expect_all("t4a.after", 0, 0, 0, 0, 0, 0);

    // Test 4b: abort on the WASH terminal tick suppresses comp_time.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int unsigned c = 0; c < 14; c++) step();
    check("t4b.wash_phase", phase, 2);
    check("t4b.wash_count", count, 9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_all("t4b.aborted", 0, 0, 0, 0, 0, 0);

    // Test 4c: abort in IDLE.
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_all("t4c.idle", 0, 0, 0, 0, 0, 0);
    check("t4c.err", err, 0);

    // Test 5a: rejected start.
    control_preset = 2'b00; washing_time = '0; start = 1'b1;
    step();
    start = 1'b0;
    check("t5a.err", err, 1);
    check("t5a.phase", phase, 0);
    step();
    check("t5a.err_clear", err, 0);
    check("t5a.phase_hold", phase, 0);

    // Test 5b: start held through a whole cycle.
    control_preset = 2'b01; start = 1'b1;
    step();
    expect_all("t5b.fill", 1, 0, 0, 0, 1, 0);
    for (int unsigned c = 0; c < 22; c++) step();
    expect_all("t5b.spin_end", 3, 7, 0, 0, 1, 0);
    check("t5b.no_err", err, 0);
    step();
    expect_all("t5b.done", 4, 0, 0, 0, 0, 1);
    step();
    expect_all("t5b.refill", 1, 0, 0, 0, 1, 0);
    start = 1'b0;
    go_idle();

    // Test 6a: tick every 4th cycle stretches FILL to 20 clocks.
    tick = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    fill_cycles = (phase == 3'd1) ? 1 : 0;
    c2_cycles = 0;
    for (int unsigned k = 1; k <= 30; k++) begin
      tick = (k % 4 == 0);
      step();
      if (phase == 3'd1) fill_cycles++;
      if (comp_time2) c2_cycles++;
    end
    check("t6a.fill_cycles", fill_cycles, 20);
    check("t6a.comp2_width", c2_cycles, 1);
    check("t6a.phase", phase, 2);

    // Test 6b: asynchronous reset mid-WASH.
    tick = 1'b1;
    step();
    check("t6b.pre_phase", phase, 2);
    #3 rst_n = 1'b0;
    #1;
    expect_all("t6b.reset", 0, 0, 0, 0, 0, 0);
    check("t6b.err", err, 0);
    #2 rst_n = 1'b1;
    step();
    expect_all("t6b.released", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
